agc_integrator_sat: RTL

Multi-channel, signed, saturating leaky integrator for the AGC loop. It sits between the error/detector stage and the gain-control stage. Each input sample is accumulated into a per-channel accumulator, with optional exponential leak and clamping at both rails. The result is delivered as a registered, valid-qualified output with saturation flags.

---
 rtl/agc_pkg.sv | 27 ++
 rtl/agc_sat_add.sv | 44 ++++
 rtl/agc_integrator_sat.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/agc_pkg.sv
// Shared definitions for the AGC leaky integrator: default widths and a signed clamp helper.
// Latency: n/a (package, no logic of its own).
// Backpressure: n/a.
// Contents: AGC_DATA_W / AGC_ACC_W defaults, sat_signed() clamps a 64-bit signed value to a narrower signed range.
package agc_pkg;

    localparam int AGC_DATA_W = 32;
    localparam int AGC_ACC_W  = 34;

    // Clamp a signed value to the representable range of a signed 'width'-bit number.
    // The result is still 64 bits wide; callers slice the low 'width' bits.
    // Valid for 1 < width < 64.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int                 width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/agc_sat_add.sv
// Leak-add-clamp datapath: acc - (leak ? acc>>>LEAK_SHIFT : 0) + data, clamped to accumulator and output ranges.
// Latency: purely combinational (0 cycles).
// Backpressure: none; evaluates every cycle.
// Ports: i_acc/i_data/i_leak_en in; o_acc (clamped accumulator), o_data (clamped output), o_sat (either clamp active) out.
module agc_sat_add
    import agc_pkg::*;
#(
    parameter int DATA_W     = AGC_DATA_W,
    parameter int ACC_W      = AGC_ACC_W,
    parameter int LEAK_SHIFT = 8
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic                     i_leak_en,
    output logic signed [ACC_W-1:0]  o_acc,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_sat
);

    // Two guard bits: acc - leak + data can never wrap at this width.
    localparam int SUM_W = ACC_W + 2;

    logic signed [ACC_W-1:0] w_shift;
    logic signed [ACC_W-1:0] w_leak;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [63:0]      w_sum_x;
    logic signed [63:0]      w_acc_sat;
    logic signed [63:0]      w_out_sat;

    // Shift kept out of the ternary so the '0 arm cannot turn it into a logical shift.
    assign w_shift   = i_acc >>> LEAK_SHIFT;
    assign w_leak    = i_leak_en ? w_shift : '0;

    assign w_sum     = SUM_W'(i_acc) - SUM_W'(w_leak) + SUM_W'(i_data);
    assign w_sum_x   = 64'(w_sum);

    assign w_acc_sat = sat_signed(w_sum_x, ACC_W);
    assign w_out_sat = sat_signed(w_acc_sat, DATA_W);

    assign o_acc     = w_acc_sat[ACC_W-1:0];
    assign o_data    = w_out_sat[DATA_W-1:0];
    assign o_sat     = (w_acc_sat != w_sum_x) || (w_out_sat != w_acc_sat);

endmodule

// File: rtl/agc_integrator_sat.sv
// Multi-channel signed saturating leaky integrator for the AGC loop, with per-channel sticky saturation flags.
// Latency: 2 cycles (S1 sample/acc read, S2 compute/write/output register); 1 sample per cycle throughput.
// Backpressure: none; downstream must take every o_valid. Samples with i_ch >= N_CH are dropped silently.
// Ports: clk_8/rst (async, active-high); i_valid,i_ch,i_data,i_clear,i_leak_en in;
//        o_valid,o_ch,o_data,o_sat (hold while idle), o_sat_sticky[N_CH] out.
module agc_integrator_sat
    import agc_pkg::*;
#(
    parameter int DATA_W     = AGC_DATA_W,
    parameter int ACC_W      = AGC_ACC_W,
    parameter int N_CH       = 4,
    parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int LEAK_SHIFT = 8
) (
    input  logic                     clk_8,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [CH_W-1:0]          i_ch,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic                     i_clear,
    input  logic                     i_leak_en,
    output logic                     o_valid,
    output logic [CH_W-1:0]          o_ch,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_sat,
    output logic [N_CH-1:0]          o_sat_sticky
);

    // Register array rather than RAM: S1 needs the S2 write value in the same cycle.
    logic signed [ACC_W-1:0]  r_acc [N_CH];

    // S1
    logic                     r_s1_vld;
    logic [CH_W-1:0]          r_s1_ch;
    logic signed [DATA_W-1:0] r_s1_data;
    logic                     r_s1_clear;
    logic                     r_s1_leak;
    logic signed [ACC_W-1:0]  r_s1_acc;

    // Output registers
    logic                     r_out_vld;
    logic [CH_W-1:0]          r_out_ch;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_out_sat;
    logic [N_CH-1:0]          r_sticky;

    logic                     w_accept;
    logic signed [ACC_W-1:0]  w_rd_acc;
    logic                     w_fwd;
    logic signed [ACC_W-1:0]  w_sum_acc;
    logic signed [DATA_W-1:0] w_sum_data;
    logic                     w_sum_sat;
    logic signed [ACC_W-1:0]  w_s2_acc_wr;
    logic signed [DATA_W-1:0] w_s2_data;
    logic                     w_s2_sat;

    assign w_accept = i_valid && (int'(i_ch) < N_CH);

    // Mux over valid channels only, so an out-of-range index never addresses the array.
    always_comb begin
        w_rd_acc = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (i_ch == CH_W'(c)) begin
                w_rd_acc = r_acc[c];
            end
        end
    end

    // The S2 write lands on the same edge S1 captures, so the array copy is one update stale.
    assign w_fwd = r_s1_vld && (r_s1_ch == i_ch);

    always_ff @(posedge clk_8 or posedge rst) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_data  <= '0;
            r_s1_clear <= 1'b0;
            r_s1_leak  <= 1'b0;
            r_s1_acc   <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_ch    <= i_ch;
                r_s1_data  <= i_data;
                r_s1_clear <= i_clear;
                r_s1_leak  <= i_leak_en;
                r_s1_acc   <= w_fwd ? w_s2_acc_wr : w_rd_acc;
            end
        end
    end

    agc_sat_add #(
        .DATA_W     (DATA_W),
        .ACC_W      (ACC_W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_sat_add (
        .i_acc     (r_s1_acc),
        .i_data    (r_s1_data),
        .i_leak_en (r_s1_leak),
        .o_acc     (w_sum_acc),
        .o_data    (w_sum_data),
        .o_sat     (w_sum_sat)
    );

    // Clear overrides the datapath entirely: zero result, no saturation reported.
    assign w_s2_acc_wr = r_s1_clear ? '0 : w_sum_acc;
    assign w_s2_data   = r_s1_clear ? '0 : w_sum_data;
    assign w_s2_sat    = r_s1_clear ? 1'b0 : w_sum_sat;

    always_ff @(posedge clk_8 or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                r_acc[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (r_s1_vld && (r_s1_ch == CH_W'(c))) begin
                    r_acc[c] <= w_s2_acc_wr;
                end
            end
        end
    end

    always_ff @(posedge clk_8 or posedge rst) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_ch   <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
            r_sticky   <= '0;
        end else begin
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_ch   <= r_s1_ch;
                r_out_data <= w_s2_data;
                r_out_sat  <= w_s2_sat;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (r_s1_vld && (r_s1_ch == CH_W'(c))) begin
                    if (r_s1_clear) begin
                        r_sticky[c] <= 1'b0;
                    end else if (w_s2_sat) begin
                        r_sticky[c] <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_valid      = r_out_vld;
    assign o_ch         = r_out_ch;
    assign o_data       = r_out_data;
    assign o_sat        = r_out_sat;
    assign o_sat_sticky = r_sticky;

endmodule
